// File: rtl/jtdd2_subcom_pkg.sv
// jtdd2_subcom_pkg
// Shared definitions for the main-CPU-side sub-CPU controller:
//   - halt handshake state encoding
//   - control register bit indices
//   - status register bit indices
package jtdd2_subcom_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REQ    = 2'd1,
        HALTED = 2'd2,
        REL    = 2'd3
    } sub_state_t;

    // Control register bits (main CPU write)
    localparam int CTL_HALT = 0;
    localparam int CTL_NMI  = 1;

    // Status register bits: {5'b0, err, main_irq, granted}
    localparam int ST_GRANTED = 0;
    localparam int ST_IRQ     = 1;
    localparam int ST_ERR     = 2;

endpackage

// File: rtl/jtdd2_subcom_fsm.sv
// jtdd2_subcom_fsm
// Bus-request handshake with the sub CPU.
//   clk, rstn  : clock, synchronous active-low reset
//   halt_req   : main CPU wants the sub bus
//   mcu_ban    : sub bus-acknowledge, active-low (0 = sub halted)
//   mcu_halt   : bus request to the sub (registered, high in REQ/HALTED)
//   granted    : sub bus owned by main (registered, high in HALTED)
//
// Handshake (valid/ready view): mcu_halt is the request; the grant is a
// low mcu_ban seen on two consecutive clocks while requesting. Releasing
// waits for mcu_ban to return high before another request may start.
module jtdd2_subcom_fsm
    import jtdd2_subcom_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic halt_req,
    input  logic mcu_ban,
    output logic mcu_halt,
    output logic granted
);

    sub_state_t state;
    logic       ban_low;   // mcu_ban was low on the previous clock in REQ

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= RUN;
            ban_low  <= 1'b0;
            mcu_halt <= 1'b0;
            granted  <= 1'b0;
        end else begin
            ban_low <= 1'b0;
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state    <= REQ;
                        mcu_halt <= 1'b1;
                    end
                end
                REQ: begin
                    if (!halt_req) begin
                        state    <= REL;
                        mcu_halt <= 1'b0;
                    end else begin
                        ban_low <= !mcu_ban;
                        // Two consecutive low samples filter a glitchy ack
                        if (!mcu_ban && ban_low) begin
                            state   <= HALTED;
                            granted <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state    <= REL;
                        mcu_halt <= 1'b0;
                        granted  <= 1'b0;
                    end
                end
                REL: begin
                    // A pending halt_req is only acted on from RUN
                    if (mcu_ban) state <= RUN;
                end
                default: begin
                    state    <= RUN;
                    mcu_halt <= 1'b0;
                    granted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/jtdd2_subcom.sv
// jtdd2_subcom
// Main-CPU-side controller for the sub CPU: control register (halt
// request, NMI), shared-RAM access gating, and sub-to-main IRQ latch.
// Optional build macro: JTDD2_SUBCOM_TIMEOUT_EN enables a shared-access
// timeout that ends a stalled access and sets a sticky err flag.
//
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   cen           : main CPU clock enable (gates ctl_we and timeout)
//   ctl_we        : write strobe to the control register
//   main_dout     : main CPU write data
//   main_rnw      : main CPU read-not-write
//   shared_cs     : main CPU selects the shared-RAM window
//   irq_ack       : write strobe clearing main_irq
//   mcu_ban       : sub bus-acknowledge, active-low
//   mcu_irqmain   : sub request to interrupt main (level)
//   shared_dout   : shared-RAM read data, 1-clk latency
//   mcu_halt      : bus request to the sub
//   mcu_nmi_set   : one-clk NMI trigger to the sub
//   com_cs        : qualified shared-RAM chip select
//   main_wait     : stall for the main CPU
//   main_din      : read data to the main CPU
//   main_irq      : IRQ to the main CPU
//   status        : {5'b0, err, main_irq, granted}
module jtdd2_subcom
    import jtdd2_subcom_pkg::*;
#(
    parameter int TMO_W = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cen,
    input  logic       ctl_we,
    input  logic [7:0] main_dout,
    input  logic       main_rnw,
    input  logic       shared_cs,
    input  logic       irq_ack,
    input  logic       mcu_ban,
    input  logic       mcu_irqmain,
    input  logic [7:0] shared_dout,
    output logic       mcu_halt,
    output logic       mcu_nmi_set,
    output logic       com_cs,
    output logic       main_wait,
    output logic [7:0] main_din,
    output logic       main_irq,
    output logic [7:0] status
);

    logic halt_req;
    logic granted;
    logic rd_ph;       // first granted read clock already spent
    logic irq_prev;
    logic err;
    logic tmo_done;
    logic ctl_wr;

    assign ctl_wr = ctl_we & cen;

    jtdd2_subcom_fsm u_fsm (
        .clk      (clk),
        .rstn     (rstn),
        .halt_req (halt_req),
        .mcu_ban  (mcu_ban),
        .mcu_halt (mcu_halt),
        .granted  (granted)
    );

    // Control register, NMI pulse, read phase, IRQ latch
    always_ff @(posedge clk) begin
        if (!rstn) begin
            halt_req    <= 1'b0;
            mcu_nmi_set <= 1'b0;
            rd_ph       <= 1'b0;
            irq_prev    <= 1'b0;
            main_irq    <= 1'b0;
        end else begin
            if (ctl_wr) halt_req <= main_dout[CTL_HALT];
            mcu_nmi_set <= ctl_wr & main_dout[CTL_NMI];

            if (!shared_cs)                 rd_ph <= 1'b0;
            else if (granted && main_rnw)   rd_ph <= 1'b1;

            irq_prev <= mcu_irqmain;
            // A new edge beats a simultaneous acknowledge
            if (mcu_irqmain && !irq_prev) main_irq <= 1'b1;
            else if (irq_ack)             main_irq <= 1'b0;
        end
    end

`ifdef JTDD2_SUBCOM_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_cond;
    logic             tmo_hit;

    assign tmo_cond = shared_cs & ~granted;
    assign tmo_done = &tmo_cnt;
    // Counter is about to saturate on this cen tick
    assign tmo_hit  = tmo_cond & cen & (tmo_cnt == {{(TMO_W-1){1'b1}}, 1'b0});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (!tmo_cond)             tmo_cnt <= '0;
            else if (cen && !tmo_done) tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit)     err <= 1'b1;
            else if (ctl_wr) err <= 1'b0;
        end
    end
`else
    logic [TMO_W-1:0] tmo_cnt;
    assign tmo_cnt  = '0;
    assign tmo_done = &tmo_cnt;
    assign err      = 1'b0;
`endif

    // Shared-RAM access gating
    always_comb begin
        com_cs    = 1'b0;
        main_wait = 1'b0;
        main_din  = 8'hFF;
        if (rstn && shared_cs) begin
            if (!granted) begin
                main_wait = !tmo_done;
            end else begin
                com_cs = 1'b1;
                if (main_rnw) begin
                    // Shared RAM has one clock of read latency
                    if (!rd_ph) main_wait = 1'b1;
                    else        main_din  = shared_dout;
                end
            end
        end
    end

    always_comb begin
        status             = 8'h00;
        status[ST_GRANTED] = granted;
        status[ST_IRQ]     = main_irq;
        status[ST_ERR]     = err;
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, main_dout[7:2]};

endmodule

// File: tb/tb_jtdd2_subcom.sv
// tb_jtdd2_subcom
// Directed bench for jtdd2_subcom. Inputs change 1 time unit after the
// rising edge; outputs are checked there, after combinational settling.
// Build with JTDD2_SUBCOM_TIMEOUT_EN to cover the timeout path (TMO_W=4).
module tb_jtdd2_subcom;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cen;
    logic       ctl_we;
    logic [7:0] main_dout;
    logic       main_rnw;
    logic       shared_cs;
    logic       irq_ack;
    logic       mcu_ban;
    logic       mcu_irqmain;
    logic [7:0] shared_dout;
    logic       mcu_halt;
    logic       mcu_nmi_set;
    logic       com_cs;
    logic       main_wait;
    logic [7:0] main_din;
    logic       main_irq;
    logic [7:0] status;

    int n_total = 0;
    int n_bad   = 0;

    // clock / reset
    always #5 clk = ~clk;

    jtdd2_subcom #(.TMO_W(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cen         (cen),
        .ctl_we      (ctl_we),
        .main_dout   (main_dout),
        .main_rnw    (main_rnw),
        .shared_cs   (shared_cs),
        .irq_ack     (irq_ack),
        .mcu_ban     (mcu_ban),
        .mcu_irqmain (mcu_irqmain),
        .shared_dout (shared_dout),
        .mcu_halt    (mcu_halt),
        .mcu_nmi_set (mcu_nmi_set),
        .com_cs      (com_cs),
        .main_wait   (main_wait),
        .main_din    (main_din),
        .main_irq    (main_irq),
        .status      (status)
    );

    // Shared-RAM model: returns 8'h5A one clock after a selected cycle
    always @(posedge clk) shared_dout <= com_cs ? 8'h5A : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl_write(input logic [7:0] val);
        main_dout = val;
        ctl_we    = 1'b1;
        tick();
        ctl_we    = 1'b0;
        #1;
    endtask

    initial begin
        rstn = 1'b0; cen = 1'b1; ctl_we = 1'b0; main_dout = 8'h00;
        main_rnw = 1'b1; shared_cs = 1'b1; irq_ack = 1'b0;
        mcu_ban = 1'b1; mcu_irqmain = 1'b0;

        // Reset: outputs quiet even with shared_cs asserted
        tick(); tick();
        #1;
        check("rst_com_cs", com_cs, 0);
        check("rst_wait", main_wait, 0);
        check("rst_din", main_din, 8'hFF);
        shared_cs = 1'b0;
        rstn = 1'b1;
        tick();
        check("idle_halt", mcu_halt, 0);
        check("idle_nmi", mcu_nmi_set, 0);
        check("idle_irq", main_irq, 0);
        check("idle_status", status, 8'h00);
        check("idle_din", main_din, 8'hFF);

        // Read while sub runs: stalled, not forwarded
        shared_cs = 1'b1; main_rnw = 1'b1;
        #1;
        check("run_rd_wait", main_wait, 1);
        check("run_rd_cs", com_cs, 0);
        check("run_rd_din", main_din, 8'hFF);

        // Halt request handshake
        ctl_write(8'h01);
        check("req_halt_e0", mcu_halt, 0);
        tick();
        check("req_halt_e1", mcu_halt, 1);
        check("req_wait", main_wait, 1);
        tick(); tick();
        mcu_ban = 1'b0;
        tick();
        check("ban_1clk", status, 8'h00);
        tick();
        check("ban_2clk", status, 8'h01);
        #1;
        check("gr_rd_cs", com_cs, 1);
        check("gr_rd_wait0", main_wait, 1);
        tick();
        check("gr_rd_wait1", main_wait, 0);
        check("gr_rd_din", main_din, 8'h5A);
        main_rnw = 1'b0;
        #1;
        check("gr_wr_wait", main_wait, 0);
        check("gr_wr_cs", com_cs, 1);
        shared_cs = 1'b0; main_rnw = 1'b1;

        // Release, then re-request during REL
        ctl_write(8'h00);
        check("rel_halt_e0", mcu_halt, 1);
        tick();
        check("rel_halt_e1", mcu_halt, 0);
        check("rel_status", status, 8'h00);
        ctl_write(8'h01);
        check("rel_hold0", mcu_halt, 0);
        tick();
        check("rel_hold1", mcu_halt, 0);
        mcu_ban = 1'b1;
        tick();
        check("rel_to_run", mcu_halt, 0);
        tick();
        check("run_to_req", mcu_halt, 1);
        ctl_write(8'h00);
        tick();
        check("req_abort", mcu_halt, 0);
        tick();

        // NMI: two writes on cen, one ignored write without cen between
        main_dout = 8'h02; ctl_we = 1'b1; cen = 1'b1;
        tick();
        check("nmi_p1", mcu_nmi_set, 1);
        cen = 1'b0;
        tick();
        check("nmi_gap", mcu_nmi_set, 0);
        cen = 1'b1;
        tick();
        check("nmi_p2", mcu_nmi_set, 1);
        ctl_we = 1'b0;
        tick();
        check("nmi_end", mcu_nmi_set, 0);
        check("nmi_halt", mcu_halt, 0);

        // IRQ latch
        mcu_irqmain = 1'b1;
        tick();
        check("irq_set", main_irq, 1);
        check("irq_status", status, 8'h02);
        mcu_irqmain = 1'b0;
        tick();
        check("irq_hold", main_irq, 1);
        mcu_irqmain = 1'b1; irq_ack = 1'b1;
        tick();
        check("irq_set_wins", main_irq, 1);
        tick();
        check("irq_ack", main_irq, 0);
        irq_ack = 1'b0;
        tick();
        check("irq_level_no_reset", main_irq, 0);
        mcu_irqmain = 1'b0;

        // Reset mid-handshake
        ctl_write(8'h01);
        tick();
        check("mid_req", mcu_halt, 1);
        rstn = 1'b0;
        tick();
        check("mid_rst", mcu_halt, 0);
        rstn = 1'b1;
        tick();
        check("mid_after", mcu_halt, 0);

        // Stalled access with the sub never acknowledging
        shared_cs = 1'b1; main_rnw = 1'b1; mcu_ban = 1'b1;
`ifdef JTDD2_SUBCOM_TIMEOUT_EN
        for (int i = 0; i < 14; i++) tick();
        check("tmo_pre_wait", main_wait, 1);
        tick();
        check("tmo_wait", main_wait, 0);
        check("tmo_din", main_din, 8'hFF);
        check("tmo_cs", com_cs, 0);
        check("tmo_status", status, 8'h04);
        tick();
        check("tmo_hold", main_wait, 0);
        shared_cs = 1'b0;
        ctl_write(8'h00);
        check("tmo_err_clr", status, 8'h00);
        shared_cs = 1'b1;
        #1;
        check("tmo_restart", main_wait, 1);
`else
        for (int i = 0; i < 20; i++) tick();
        check("stall_wait", main_wait, 1);
        check("stall_status", status, 8'h00);
`endif
        shared_cs = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
